// File: rtl/regfile_wb_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Brief    : Writeback request, decode lookup and register-file write bundle.
//  Revision : 1.0
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) ();

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;

  logic                 iss_valid;
  logic [4:0]           iss_rd;
  logic [4:0]           rs0;
  logic [4:0]           rs1;
  logic                 hazard0;
  logic                 hazard1;
  logic                 hazard_rd;
  logic                 flush;

  logic                 rf_en;
  logic [4:0]           rf_selin;
  logic [XLEN-1:0]      rf_D;

  modport slave (
    input  req_valid, req_rd, req_data, iss_valid, iss_rd, rs0, rs1, flush,
    output req_ready, hazard0, hazard1, hazard_rd, rf_en, rf_selin, rf_D
  );

  modport master (
    output req_valid, req_rd, req_data, iss_valid, iss_rd, rs0, rs1, flush,
    input  req_ready, hazard0, hazard1, hazard_rd, rf_en, rf_selin, rf_D
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Brief    : Round-robin share of the register-file write port plus a busy
//             scoreboard for RAW/WAW hazard lookups at decode.
//  Revision : 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input wire clock,
  input wire resetn,
  regfile_wb_arbiter_if.slave bus
);

  localparam int            c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_PW:0] c_NREQ = (c_PW+1)'(NREQ);
  localparam logic [c_PW:0] c_ONE  = (c_PW+1)'(1);

  // Reduce a value in [0, 2*NREQ) to a requester index.
  function automatic logic [c_PW-1:0] f_wrap(input logic [c_PW:0] a);
    logic [c_PW:0] t;
    t = (a >= c_NREQ) ? (a - c_NREQ) : a;
    return t[c_PW-1:0];
  endfunction

  logic [c_PW-1:0] r_ptr;
  logic            r_rf_en;
  logic [4:0]      r_rf_selin;
  logic [XLEN-1:0] r_rf_d;
  logic [31:0]     r_busy;

  logic [NREQ-1:0] w_grant;
  logic [c_PW-1:0] w_gidx;
  logic [c_PW-1:0] w_cand;
  logic            w_xfer;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [c_PW-1:0] w_ptr_nxt;
  logic [31:0]     w_busy_nxt;

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_cand  = '0;
    w_xfer  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = f_wrap({1'b0, r_ptr} + (c_PW+1)'(k));
      if (!w_xfer && bus.req_valid[w_cand]) begin
        w_xfer = 1'b1;
        w_gidx = w_cand;
      end
    end
    if (w_xfer) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_rd   = bus.req_rd[i*5 +: 5];
        w_sel_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign w_ptr_nxt = f_wrap({1'b0, w_gidx} + c_ONE);

  // Set beats clear so a re-issue racing its own writeback stays busy; flush beats both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_en) begin
      w_busy_nxt[r_rf_selin] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
      w_busy_nxt[bus.iss_rd] = 1'b1;
    end
    if (bus.flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr      <= '0;
      r_rf_en    <= 1'b0;
      r_rf_selin <= '0;
      r_rf_d     <= '0;
      r_busy     <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_xfer) begin
        r_ptr      <= w_ptr_nxt;
        r_rf_en    <= (w_sel_rd != 5'd0);
        r_rf_selin <= w_sel_rd;
        r_rf_d     <= w_sel_data;
      end else begin
        r_rf_en    <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rf_en     = r_rf_en;
  assign bus.rf_selin  = r_rf_selin;
  assign bus.rf_D      = r_rf_d;

  assign bus.hazard0   = (bus.rs0    != 5'd0) & r_busy[bus.rs0];
  assign bus.hazard1   = (bus.rs1    != 5'd0) & r_busy[bus.rs1];
  assign bus.hazard_rd = (bus.iss_rd != 5'd0) & r_busy[bus.iss_rd];

endmodule
`default_nettype wire
